systolic_skew_feeder: RTL and testbench

- Upstream edge stage of the vector systolic array; drives the a-inputs of the left-column PEs.
- Accepts one column slice per cycle over a valid/ready handshake. A slice is one 8-lane vector per array row.
- Emits each slice diagonally skewed: row r sees the slice r cycles after row 0, so operands meet their partners in the PE wavefront.
- Tracks tile boundaries and flushes the skew after the last slice, then signals completion.

---
 rtl/systolic_skew_feeder_if.sv | 26 ++
 rtl/systolic_skew_feeder.sv | 154 +++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_skew_feeder_if.sv
// Slice handshake bundle between the slice producer and systolic_skew_feeder.
// DATA_W must equal ROWS*LANES*REG_WIDTH of the attached feeder.
interface systolic_skew_feeder_if #(
  parameter int unsigned DATA_W = 512
);

  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [DATA_W-1:0] in_data;

  modport master (
    output in_valid,
    output in_last,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_last,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/systolic_skew_feeder.sv
// Left-edge feeder of the vector systolic array: accepts one column slice per
// cycle and presents row r of each slice r cycles after row 0.
// Optional build macro SKEW_ZERO_PAD_EN: zero the lanes of any row whose
// out_valid is low.
module systolic_skew_feeder #(
  parameter int unsigned REG_WIDTH = 16,
  parameter int unsigned LANES     = 8,
  parameter int unsigned ROWS      = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  systolic_skew_feeder_if.slave           slice_bus,
  output logic [ROWS*LANES*REG_WIDTH-1:0] out_data,
  output logic [ROWS-1:0]                 out_valid,
  output logic                            out_done,
  output logic [CNT_WIDTH-1:0]            slice_cnt
);

  localparam int unsigned ROW_W   = LANES * REG_WIDTH;
  localparam int unsigned DRAIN_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  state_t               state_q;
  state_t               state_nxt;
  logic [DRAIN_W-1:0]   drain_q;
  logic [DRAIN_W-1:0]   drain_nxt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 ready_q;
  logic                 ready_nxt;
  logic                 xfer;
  logic [ROWS-1:0]      last_q;

  // Ready is held low for the whole cycle while reset is asserted.
  assign slice_bus.in_ready = ready_q & ~rst;
  assign xfer               = slice_bus.in_valid & slice_bus.in_ready;

  // Tile control state, drain counter, slice counter and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      drain_q   <= '0;
      slice_cnt <= '0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_nxt;
      drain_q   <= drain_nxt;
      slice_cnt <= cnt_nxt;
      ready_q   <= ready_nxt;
    end
  end

  // Next-state: stream slices until in_last, then hold off for ROWS-1 cycles
  // so the previous tile clears the deepest delay line.
  always_comb begin
    state_nxt = state_q;
    drain_nxt = drain_q;
    cnt_nxt   = slice_cnt;
    ready_nxt = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          cnt_nxt   = CNT_WIDTH'(1);
          drain_nxt = DRAIN_W'(ROWS - 1);
          if (!slice_bus.in_last) begin
            state_nxt = STREAM;
          end else if (ROWS > 1) begin
            state_nxt = DRAIN;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      STREAM: begin
        if (xfer) begin
          cnt_nxt   = (slice_cnt == '1) ? slice_cnt : slice_cnt + CNT_WIDTH'(1);
          drain_nxt = DRAIN_W'(ROWS - 1);
          if (slice_bus.in_last) begin
            if (ROWS > 1) begin
              state_nxt = DRAIN;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      DRAIN: begin
        drain_nxt = drain_q - DRAIN_W'(1);
        if (drain_q == DRAIN_W'(1)) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    ready_nxt = (state_nxt != DRAIN);
  end

  // End-of-tile tag rides a ROWS-deep line so it leaves with the last slice's
  // final row.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
    end else begin
      last_q <= ROWS'({last_q, xfer & slice_bus.in_last});
    end
  end

  assign out_done = last_q[ROWS-1];

  // Row r delay line: r+1 stages, valid bit travelling with the data.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar k = 0; k <= r; k++) begin : g_stage
      logic [ROW_W-1:0] d_q;
      logic             v_q;
      logic [ROW_W-1:0] d_in;
      logic             v_in;

      if (k == 0) begin : g_first
        // Head stage only captures on a transfer; bubbles keep the last slice.
        assign v_in = xfer;
        assign d_in = xfer ? slice_bus.in_data[r*ROW_W +: ROW_W] : d_q;
      end else begin : g_next
        assign v_in = g_stage[k-1].v_q;
        assign d_in = g_stage[k-1].d_q;
      end

      // One skew stage; with zero padding the output stage drops invalid data.
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
          d_q <= '0;
        end else begin
          v_q <= v_in;
`ifdef SKEW_ZERO_PAD_EN
          d_q <= ((k == r) && !v_in) ? '0 : d_in;
`else
          d_q <= d_in;
`endif
        end
      end
    end

    assign out_data[r*ROW_W +: ROW_W] = g_stage[r].d_q;
    assign out_valid[r]               = g_stage[r].v_q;
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder with a per-row scoreboard.
// Main instance: ROWS=4, CNT_WIDTH=4. Second instance: ROWS=1.
module tb_systolic_skew_feeder;

  localparam int unsigned REG_W   = 16;
  localparam int unsigned LANES   = 8;
  localparam int unsigned ROWS    = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned ROW_W   = LANES * REG_W;
  localparam int unsigned DATA_W  = ROWS * ROW_W;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [ROW_W-1:0] data;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  int   exp_cnt = 0;
  bit   in_tile = 1'b0;

  exp_t             row_q [ROWS][$];
  int               done_q [$];
  logic [ROW_W-1:0] prev_d [ROWS];

  systolic_skew_feeder_if #(.DATA_W(DATA_W)) bus ();
  systolic_skew_feeder_if #(.DATA_W(ROW_W))  bus1 ();

  logic [DATA_W-1:0] out_data;
  logic [ROWS-1:0]   out_valid;
  logic              out_done;
  logic [CNT_W-1:0]  slice_cnt;

  logic [ROW_W-1:0]  out_data1;
  logic [0:0]        out_valid1;
  logic              out_done1;
  logic [15:0]       slice_cnt1;

  systolic_skew_feeder #(
    .REG_WIDTH(REG_W), .LANES(LANES), .ROWS(ROWS), .CNT_WIDTH(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .slice_bus(bus),
    .out_data(out_data), .out_valid(out_valid),
    .out_done(out_done), .slice_cnt(slice_cnt)
  );

  systolic_skew_feeder #(
    .REG_WIDTH(REG_W), .LANES(LANES), .ROWS(1), .CNT_WIDTH(16)
  ) dut1 (
    .clk(clk), .rst(rst), .slice_bus(bus1),
    .out_data(out_data1), .out_valid(out_valid1),
    .out_done(out_done1), .slice_cnt(slice_cnt1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [ROW_W-1:0] obs,
                     input logic [ROW_W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [ROW_W-1:0] mk_row(input int r, input int k);
    logic [ROW_W-1:0] v;
    for (int l = 0; l < int'(LANES); l++)
      v[l*REG_W +: REG_W] = REG_W'(32'h0100 * r + 32'h0010 * l + k);
    return v;
  endfunction

  function automatic int pending();
    int n = done_q.size();
    for (int r = 0; r < int'(ROWS); r++) n += row_q[r].size();
    return n;
  endfunction

  // Present slice k; wait (bounded) for ready, record what the DUT owes.
  task automatic send(input int k, input bit last, output int stalls);
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    for (int r = 0; r < int'(ROWS); r++) bus.in_data[r*ROW_W +: ROW_W] = mk_row(r, k);
    stalls = 0;
    while (!bus.in_ready && stalls < 20) begin
      @(posedge clk); #1;
      stalls++;
    end
    chk("xfer_ready", ROW_W'(bus.in_ready), ROW_W'(1));
    if (bus.in_ready) begin
      for (int r = 0; r < int'(ROWS); r++)
        row_q[r].push_back('{data: mk_row(r, k), cyc: cyc + 1 + r});
      if (last) done_q.push_back(cyc + int'(ROWS));
      if (!in_tile) exp_cnt = 1;
      else if (exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1;
      in_tile = !last;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Count cycles with in_ready low (bounded).
  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.in_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Scoreboard: every row every cycle, plus the done pulse.
  always @(negedge clk) begin
    bit               exp_v;
    bit               exp_d;
    logic [ROW_W-1:0] idle_d;
    exp_t             e;
    if (mon_en) begin
      for (int r = 0; r < int'(ROWS); r++) begin
        exp_v = (row_q[r].size() > 0) && (row_q[r][0].cyc == cyc);
        chk($sformatf("valid_r%0d", r), ROW_W'(out_valid[r]), ROW_W'(exp_v));
        if (exp_v) begin
          e = row_q[r].pop_front();
          prev_d[r] = e.data;
          chk($sformatf("data_r%0d", r), out_data[r*ROW_W +: ROW_W], e.data);
        end else begin
`ifdef SKEW_ZERO_PAD_EN
          idle_d = '0;
`else
          idle_d = prev_d[r];
`endif
          chk($sformatf("idle_data_r%0d", r), out_data[r*ROW_W +: ROW_W], idle_d);
        end
      end
      exp_d = (done_q.size() > 0) && (done_q[0] == cyc);
      chk("out_done", ROW_W'(out_done), ROW_W'(exp_d));
      if (exp_d) void'(done_q.pop_front());
    end
  end

  initial begin
    int st;
    int n;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = '0;
    bus1.in_valid = 1'b0;
    bus1.in_last  = 1'b0;
    bus1.in_data  = '0;
    for (int r = 0; r < int'(ROWS); r++) prev_d[r] = '0;

    // Reset
    rst = 1'b1;
    #1;
    chk("ready_in_rst", ROW_W'(bus.in_ready), ROW_W'(0));
    chk("ready1_in_rst", ROW_W'(bus1.in_ready), ROW_W'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_valid", ROW_W'(out_valid), ROW_W'(0));
    chk("rst_done", ROW_W'(out_done), ROW_W'(0));
    chk("rst_cnt", ROW_W'(slice_cnt), ROW_W'(0));
    for (int r = 0; r < int'(ROWS); r++)
      chk("rst_data", out_data[r*ROW_W +: ROW_W], ROW_W'(0));
    rst    = 1'b0;
    mon_en = 1'b1;
    #1;
    chk("ready_after_rst", ROW_W'(bus.in_ready), ROW_W'(1));

    // Single tile of three back-to-back slices
    send(1, 1'b0, st);
    send(2, 1'b0, st);
    send(3, 1'b1, st);
    chk("tileA_cnt", ROW_W'(slice_cnt), ROW_W'(exp_cnt));
    wait_ready(n);
    chk("tileA_drain_len", ROW_W'(n), ROW_W'(ROWS - 1));

    // Bubble between two slices
    send(4, 1'b0, st);
    idle(1);
    send(6, 1'b1, st);
    chk("bubble_cnt", ROW_W'(slice_cnt), ROW_W'(2));
    wait_ready(n);
    chk("bubble_drain_len", ROW_W'(n), ROW_W'(ROWS - 1));

    // Back-to-back tiles: next tile's valid held across the drain
    send(7, 1'b0, st);
    send(8, 1'b1, st);
    send(9, 1'b0, st);
    chk("b2b_stalls", ROW_W'(st), ROW_W'(ROWS - 1));
    chk("b2b_cnt_restart", ROW_W'(slice_cnt), ROW_W'(1));
    send(10, 1'b1, st);
    wait_ready(n);

    // Reset mid-tile after 2 slices
    send(11, 1'b0, st);
    send(12, 1'b0, st);
    rst = 1'b1;
    #1;
    chk("midrst_ready_low", ROW_W'(bus.in_ready), ROW_W'(0));
    @(posedge clk); #1;
    for (int r = 0; r < int'(ROWS); r++) begin
      row_q[r].delete();
      prev_d[r] = '0;
    end
    done_q.delete();
    exp_cnt = 0;
    in_tile = 1'b0;
    rst     = 1'b0;
    #1;
    chk("midrst_valid", ROW_W'(out_valid), ROW_W'(0));
    chk("midrst_cnt", ROW_W'(slice_cnt), ROW_W'(0));
    chk("midrst_done", ROW_W'(out_done), ROW_W'(0));
    chk("midrst_ready", ROW_W'(bus.in_ready), ROW_W'(1));
    idle(6);

    // Counter saturation: 20 slices without in_last
    for (int k = 0; k < 20; k++) begin
      send(20 + k, 1'b0, st);
      if (k == 14) chk("sat_cnt_15", ROW_W'(slice_cnt), ROW_W'(CNT_MAX));
    end
    chk("sat_cnt_20", ROW_W'(slice_cnt), ROW_W'(CNT_MAX));
    send(40, 1'b1, st);
    chk("sat_cnt_last", ROW_W'(slice_cnt), ROW_W'(CNT_MAX));
    wait_ready(n);

    // ROWS=1 instance: single slice with in_last
    chk("r1_ready_before", ROW_W'(bus1.in_ready), ROW_W'(1));
    bus1.in_valid = 1'b1;
    bus1.in_last  = 1'b1;
    bus1.in_data  = mk_row(2, 50);
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    bus1.in_last  = 1'b0;
    chk("r1_valid", ROW_W'(out_valid1), ROW_W'(1));
    chk("r1_done", ROW_W'(out_done1), ROW_W'(1));
    chk("r1_ready", ROW_W'(bus1.in_ready), ROW_W'(1));
    chk("r1_data", out_data1, mk_row(2, 50));
    chk("r1_cnt", ROW_W'(slice_cnt1), ROW_W'(1));
    @(posedge clk); #1;
    chk("r1_valid_after", ROW_W'(out_valid1), ROW_W'(0));
    chk("r1_done_after", ROW_W'(out_done1), ROW_W'(0));
    chk("r1_ready_after", ROW_W'(bus1.in_ready), ROW_W'(1));

    // Let everything owed come out, then confirm nothing is left
    for (int i = 0; i < 20 && pending() != 0; i++) begin
      @(posedge clk); #1;
    end
    idle(2);
    chk("sb_empty", ROW_W'(pending()), ROW_W'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
